// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready stream buffer with DEPTH entries of elasticity,
// first-word-fall-through output and a synchronous flush.
// Optional build macro STREAM_FIFO_LEVEL_EN adds the level/almost_full outputs.
module stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and >= 2");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("stream_fifo: DATA_W must be >= 1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic              push, pop;

  assign m_valid = (count_q != '0);
  assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  assign s_ready = s_ready_q;
  assign push    = s_valid & s_ready_q;
  assign pop     = m_valid & m_ready;

`ifdef STREAM_FIFO_LEVEL_EN
  assign level       = count_q;
  assign almost_full = (count_q >= DEPTH_C - CW'(1));
`endif

  // Next-state for pointers, occupancy and the registered s_ready; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    s_ready_d = (count_d < DEPTH_C) & ~flush;
  end

  // Control state register; s_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Payload storage, not reset; data presented during a flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed table-driven bench for stream_fifo (DATA_W=32, DEPTH=8).
module tb_stream_fifo;

  localparam int DW = 32;
  localparam int DP = 8;
  localparam int LW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef STREAM_FIFO_LEVEL_EN
  logic [LW-1:0] level;
  logic          almost_full;
`endif

  stream_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          sr_e;
    logic          mv_e;
    logic [DW-1:0] md_e;
    int            lvl_e;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic sv, input logic [DW-1:0] sd, input logic mr,
                     input logic sr_e, input logic mv_e, input logic [DW-1:0] md_e,
                     input int lvl_e);
    vecs[nv].sv = sv;   vecs[nv].sd = sd;     vecs[nv].mr = mr;
    vecs[nv].sr_e = sr_e; vecs[nv].mv_e = mv_e; vecs[nv].md_e = md_e;
    vecs[nv].lvl_e = lvl_e;
    nv++;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic sr_e, input logic mv_e,
                         input logic [DW-1:0] md_e, input int lvl_e);
    chk({nm, ".s_ready"}, DW'(s_ready), DW'(sr_e));
    chk({nm, ".m_valid"}, DW'(m_valid), DW'(mv_e));
    chk({nm, ".m_data"},  m_data, md_e);
`ifdef STREAM_FIFO_LEVEL_EN
    if (lvl_e >= 0) begin
      chk({nm, ".level"},       DW'(level), DW'(lvl_e));
      chk({nm, ".almost_full"}, DW'(almost_full), DW'(lvl_e >= DP - 1));
    end
`endif
  endtask

  // Drive inputs just after a falling edge, then sample outputs 1 time unit later.
  task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    @(negedge clk);
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // Single word with 5 stall cycles, then one pop.
    add(1, 32'hA5A5_0001, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 1, 32'hA5A5_0001, 1);
    add(0, 0, 1, 1, 1, 32'hA5A5_0001, 1);
    add(0, 0, 0, 1, 0, 0, 0);
    // Fill to full with 0x10..0x17.
    for (int i = 0; i < 8; i++)
      add(1, 32'h10 + i, 0, 1, (i > 0), (i > 0) ? 32'h10 : 32'h0, i);
    // Full: 0x18 held, not accepted; one pop frees a slot one edge later.
    add(1, 32'h18, 0, 0, 1, 32'h10, 8);
    add(1, 32'h18, 1, 0, 1, 32'h10, 8);
    add(1, 32'h18, 0, 1, 1, 32'h11, 7);
    // Drain 0x11..0x18.
    for (int k = 0; k < 8; k++) add(0, 0, 1, (k > 0), 1, 32'h11 + k, 8 - k);
    add(0, 0, 0, 1, 0, 0, 0);

    // Reset: held low 3 cycles.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk_out("reset", 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("post_release", 0, 0, 0, 0);

    // Table-driven section.
    for (int v = 0; v < nv; v++) begin
      drive(vecs[v].sv, vecs[v].sd, vecs[v].mr, 0);
      chk_out($sformatf("vec%0d", v), vecs[v].sr_e, vecs[v].mv_e, vecs[v].md_e, vecs[v].lvl_e);
    end

    // Concurrent streaming of 0..39 with wrap-around; occupancy stays at 1.
    for (int k = 0; k <= 40; k++) begin
      drive((k < 40), DW'(k), 1, 0);
      chk_out($sformatf("stream%0d", k), 1, (k > 0), (k > 0) ? DW'(k - 1) : '0, (k > 0) ? 1 : 0);
    end
    drive(0, 0, 0, 0);
    chk_out("stream_end", 1, 0, 0, 0);

    // Flush priority over push and pop.
    for (int i = 0; i < 5; i++) drive(1, 32'h100 + i, 0, 0);
    drive(1, 32'hDEAD, 1, 1);
    chk_out("flush_cyc", 1, 1, 32'h100, 5);
    drive(0, 0, 0, 0);
    chk_out("after_flush", 0, 0, 0, 0);
    drive(1, 32'h77, 0, 0);
    chk_out("flush_recover", 1, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk_out("flush_first_out", 1, 1, 32'h77, 1);
    drive(0, 0, 0, 0);
    chk_out("flush_empty", 1, 0, 0, 0);

    // Asynchronous reset mid-stream with 6 entries.
    for (int i = 0; i < 6; i++) drive(1, 32'h200 + i, 0, 0);
    drive(0, 0, 0, 0);
    chk_out("pre_areset", 1, 1, 32'h200, 6);
    #1 rst_n = 1'b0;
    #1;
    chk_out("areset_now", 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("areset_release", 0, 0, 0, 0);
    drive(1, 32'h55, 0, 0);
    chk_out("areset_push", 1, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk_out("areset_first", 1, 1, 32'h55, 1);
    drive(0, 0, 0, 0);
    chk_out("areset_empty", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
